alu_flag_reg_unit: RTL and testbench
====================================

// Module: alu_flag_reg_unit
// PURPOSE
//  Registered, parametrised ALU status-flag unit: computes C/Z/S/O from the ALU result and operand
//  sign bits, holds them in a flag register with per-flag write mask, chains Z across multi-word
//  ADDC/SUBB, keeps a sticky overflow bit and a saturating overflow-event counter. Sits directly
//  after the ALU datapath; flag outputs feed branch/condition logic and the status register.
// PARAMETERS
//  DWIDTH     32  result/operand width in bits (>=2)
//  CNT_WIDTH   8  width of saturating overflow-event counter
// PORTS
//  clk          in   1          system clock, all state on rising edge
//  rst          in   1          synchronous, active-high reset
//  in_valid     in   1          ALU result valid this cycle; flags update only when high
//  opsel        in   3          000 ADD,001 ADDC,010 SUB,011 SUBB,100 AND,101 OR,110 XOR,111 SHIFT
//  mode         in   1          1 = signed arithmetic (O computed), 0 = unsigned (O forced 0)
//  cout         in   1          adder carry-out (ADD/SUB ops) or shifted-out bit (SHIFT)
//  a_msb        in   1          operand A bit DWIDTH-1
//  b_msb        in   1          operand B bit DWIDTH-1 (un-inverted, as presented to ALU)
//  result       in   DWIDTH     ALU result
//  flag_we      in   4          per-flag write mask {O,S,Z,C}; 0 = flag holds on in_valid
//  flag_ld      in   1          load flags from flag_wdata (context restore)
//  flag_wdata   in   4          {O,S,Z,C} value for flag_ld
//  sticky_clr   in   1          clear sticky overflow and event counter
//  c_flag       out  1          registered carry / no-borrow
//  z_flag       out  1          registered zero
//  s_flag       out  1          registered sign
//  o_flag       out  1          registered signed overflow
//  so_flag      out  1          sticky overflow
//  ovf_cnt      out  CNT_WIDTH  saturating count of accepted ops with O=1
//  flag_valid   out  1          high one cycle after each accepted in_valid
// BEHAVIOUR
//  - Reset: c/z/s/o/so_flag=0, ovf_cnt=0, flag_valid=0. rst wins over every other input.
//  - Latency 1: flags from in_valid at edge N visible after edge N; flag_valid=in_valid delayed 1.
//  - Next-flag compute (combinational, r=result[DWIDTH-1]):
//    S = r. Z = (result==0) for ADD/SUB/logic/SHIFT; Z = (result==0) & z_flag for ADDC/SUBB.
//    C = cout for ADD/ADDC and SHIFT; C = cout (1 = no borrow) for SUB/SUBB; C = 0 for AND/OR/XOR.
//    O (mode=1): ADD/ADDC: (a_msb==b_msb)&(r!=a_msb); SUB/SUBB: (a_msb!=b_msb)&(r!=a_msb);
//    logic/SHIFT: 0. mode=0: O = 0 for all ops.
//  - Update priority per edge: rst > flag_ld > in_valid. flag_ld loads all four flags from
//    flag_wdata regardless of flag_we and suppresses the in_valid update; flag_valid still follows
//    in_valid. in_valid with flag_we[i]=0 leaves flag i unchanged.
//  - Sticky: on accepted in_valid (flag_ld=0) with computed O=1 and flag_we[3]=1, so_flag<=1 and
//    ovf_cnt increments, saturating at 2^CNT_WIDTH-1 (no wrap). flag_ld never touches so_flag/ovf_cnt.
//  - sticky_clr same cycle as a new overflow: set/increment wins -> so_flag=1, ovf_cnt=1.
//  - No in_valid: all state holds; flag_valid=0.
// TESTING
//  1 Reset mid-stream: in_valid ADD overflow with rst=1 -> after edge all flags 0, ovf_cnt=0, flag_valid=0.
//  2 ADD mode=1 DWIDTH=32: a=0x7FFFFFFF,b=1,result=0x80000000,cout=0 -> C0 Z0 S1 O1, so_flag=1, ovf_cnt=1.
//  3 SUB mode=1: a=5,b=5,result=0,cout=1 -> C1 Z1 S0 O0; SUB a=0,b=1,result=0xFFFFFFFF,cout=0 -> C0 S1 Z0.
//  4 64-bit chain: ADD low 0+0 result 0 (Z=1), then ADDC high result 0 -> Z=1; ADD low result 1, ADDC high 0 -> Z=0.
//  5 flag_we=4'b0001 on XOR result 0 -> only C updates (to 0); flag_ld=1 with in_valid, wdata=4'b1010 -> flags O1 S0 Z1 C0.
//  6 CNT_WIDTH=2: 5 overflowing ADDs -> ovf_cnt stops at 3; sticky_clr with 6th overflow -> so_flag=1, ovf_cnt=1.

Source files
------------

// File: rtl/alu_flag_reg_unit_if.sv
// Bus between the ALU datapath and the flag register unit: ALU result/status in, registered flags out.
interface alu_flag_reg_unit_if #(
   parameter int DWIDTH    = 32,
   parameter int CNT_WIDTH = 8
);
   logic                 in_valid;
   logic [2:0]           opsel;
   logic                 mode;
   logic                 cout;
   logic                 a_msb;
   logic                 b_msb;
   logic [DWIDTH-1:0]    result;
   logic [3:0]           flag_we;
   logic                 flag_ld;
   logic [3:0]           flag_wdata;
   logic                 sticky_clr;
   logic                 c_flag;
   logic                 z_flag;
   logic                 s_flag;
   logic                 o_flag;
   logic                 so_flag;
   logic [CNT_WIDTH-1:0] ovf_cnt;
   logic                 flag_valid;

   modport master (
      output in_valid, opsel, mode, cout, a_msb, b_msb, result,
             flag_we, flag_ld, flag_wdata, sticky_clr,
      input  c_flag, z_flag, s_flag, o_flag, so_flag, ovf_cnt, flag_valid
   );

   modport slave (
      input  in_valid, opsel, mode, cout, a_msb, b_msb, result,
             flag_we, flag_ld, flag_wdata, sticky_clr,
      output c_flag, z_flag, s_flag, o_flag, so_flag, ovf_cnt, flag_valid
   );
endinterface

// File: rtl/alu_flag_reg_unit.sv
// Registered C/Z/S/O flag unit with write mask, multi-word Z chaining, context load,
// sticky overflow and a saturating overflow-event counter.
module alu_flag_reg_unit #(
   parameter int DWIDTH    = 32,
   parameter int CNT_WIDTH = 8
) (
   input logic                 clk,
   input logic                 rst,
   alu_flag_reg_unit_if.slave  bus
);
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDC = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_SUBB = 3'b011;
   localparam logic [2:0] OP_SHFT = 3'b111;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // Flag vector packed as {O,S,Z,C}, matching flag_we / flag_wdata.
   logic [3:0]           flags_q, flags_d, nxt;
   logic                 so_q, so_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 vld_q;
   logic                 r_msb, res_zero, ovf_evt;

   assign r_msb    = bus.result[DWIDTH-1];
   assign res_zero = (bus.result == '0);

   always_comb begin
      nxt    = 4'b0000;
      nxt[2] = r_msb;
      nxt[1] = res_zero;
      unique case (bus.opsel)
         OP_ADD, OP_ADDC: begin
            nxt[0] = bus.cout;
            nxt[3] = bus.mode & (bus.a_msb == bus.b_msb) & (r_msb != bus.a_msb);
         end
         OP_SUB, OP_SUBB: begin
            nxt[0] = bus.cout;
            nxt[3] = bus.mode & (bus.a_msb != bus.b_msb) & (r_msb != bus.a_msb);
         end
         OP_SHFT: nxt[0] = bus.cout;
         default: ;
      endcase
      // Upper words of a chained op are only zero if every lower word was zero.
      if (bus.opsel == OP_ADDC || bus.opsel == OP_SUBB)
         nxt[1] = res_zero & flags_q[1];
   end

   always_comb begin
      flags_d = flags_q;
      if (bus.flag_ld)
         flags_d = bus.flag_wdata;
      else if (bus.in_valid)
         flags_d = (bus.flag_we & nxt) | (~bus.flag_we & flags_q);
   end

   assign ovf_evt = bus.in_valid & ~bus.flag_ld & nxt[3] & bus.flag_we[3];

   always_comb begin
      so_d  = so_q;
      cnt_d = cnt_q;
      if (ovf_evt) begin
         so_d  = 1'b1;
         if (bus.sticky_clr)
            cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
      end else if (bus.sticky_clr) begin
         so_d  = 1'b0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 4'b0000;
         so_q    <= 1'b0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         so_q    <= so_d;
         cnt_q   <= cnt_d;
         vld_q   <= bus.in_valid;
      end
   end

   assign bus.c_flag     = flags_q[0];
   assign bus.z_flag     = flags_q[1];
   assign bus.s_flag     = flags_q[2];
   assign bus.o_flag     = flags_q[3];
   assign bus.so_flag    = so_q;
   assign bus.ovf_cnt    = cnt_q;
   assign bus.flag_valid = vld_q;
endmodule

// File: tb/tb_alu_flag_reg_unit.sv
// Directed-vector bench for alu_flag_reg_unit (DWIDTH=32, CNT_WIDTH=2 to reach saturation quickly).
module tb_alu_flag_reg_unit;
   localparam int DW = 32;
   localparam int CW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   alu_flag_reg_unit_if #(.DWIDTH(DW), .CNT_WIDTH(CW)) bus ();

   alu_flag_reg_unit #(.DWIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bus.in_valid   = 1'b0;
      bus.flag_ld    = 1'b0;
      bus.sticky_clr = 1'b0;
   endtask

   task automatic op(input logic [2:0] sel, input logic md, input logic co,
                     input logic am, input logic bm, input logic [DW-1:0] res,
                     input logic [3:0] we = 4'hF);
      bus.in_valid = 1'b1;
      bus.opsel    = sel;
      bus.mode     = md;
      bus.cout     = co;
      bus.a_msb    = am;
      bus.b_msb    = bm;
      bus.result   = res;
      bus.flag_we  = we;
   endtask

   function automatic logic [3:0] flags();
      return {bus.o_flag, bus.s_flag, bus.z_flag, bus.c_flag};
   endfunction

   initial begin
      bus.in_valid   = 1'b0;
      bus.opsel      = 3'b000;
      bus.mode       = 1'b0;
      bus.cout       = 1'b0;
      bus.a_msb      = 1'b0;
      bus.b_msb      = 1'b0;
      bus.result     = '0;
      bus.flag_we    = 4'hF;
      bus.flag_ld    = 1'b0;
      bus.flag_wdata = 4'h0;
      bus.sticky_clr = 1'b0;

      // reset wins over an overflowing ADD
      op(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000);
      tick();
      chk("rst_flags", 32'(flags()), 32'h0);
      chk("rst_so", 32'(bus.so_flag), 32'h0);
      chk("rst_cnt", 32'(bus.ovf_cnt), 32'h0);
      chk("rst_vld", 32'(bus.flag_valid), 32'h0);
      rst = 1'b0;

      // signed ADD overflow 0x7FFFFFFF + 1
      op(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000);
      tick();
      chk("add_ovf_flags", 32'(flags()), 32'hC);
      chk("add_ovf_so", 32'(bus.so_flag), 32'h1);
      chk("add_ovf_cnt", 32'(bus.ovf_cnt), 32'h1);
      chk("add_ovf_vld", 32'(bus.flag_valid), 32'h1);
      tick();
      chk("idle_vld", 32'(bus.flag_valid), 32'h0);
      chk("idle_hold", 32'(flags()), 32'hC);

      // SUB 5-5 and SUB 0-1
      op(3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      chk("sub_eq", 32'(flags()), 32'h3);
      op(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
      tick();
      chk("sub_borrow", 32'(flags()), 32'h4);

      // 64-bit Z chaining
      op(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      chk("chain_lo0", 32'(flags()), 32'h2);
      op(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      chk("chain_hi0", 32'(flags()), 32'h2);
      op(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1);
      tick();
      chk("chain_lo1", 32'(flags()), 32'h0);
      op(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      chk("chain_hi_nz", 32'(flags()), 32'h0);

      // write mask: only C updates on XOR result 0
      op(3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2);
      tick();
      chk("pre_mask", 32'(flags()), 32'h1);
      op(3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'b0001);
      tick();
      chk("mask_c_only", 32'(flags()), 32'h0);

      // flag_ld beats in_valid and leaves sticky state alone
      op(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000);
      bus.flag_ld    = 1'b1;
      bus.flag_wdata = 4'b1010;
      tick();
      chk("ld_flags", 32'(flags()), 32'hA);
      chk("ld_cnt", 32'(bus.ovf_cnt), 32'h1);
      chk("ld_vld", 32'(bus.flag_valid), 32'h1);

      // unsigned mode forces O=0; masked O does not count
      op(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000);
      tick();
      chk("unsigned_o0", 32'(flags()), 32'h4);
      op(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 4'b0111);
      tick();
      chk("mask_o_flags", 32'(flags()), 32'h4);
      chk("mask_o_cnt", 32'(bus.ovf_cnt), 32'h1);

      // SHIFT carries shifted-out bit, no overflow
      op(3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000);
      tick();
      chk("shift", 32'(flags()), 32'h5);

      // sticky clear, then SUBB overflow counts
      bus.sticky_clr = 1'b1;
      tick();
      chk("clr_so", 32'(bus.so_flag), 32'h0);
      chk("clr_cnt", 32'(bus.ovf_cnt), 32'h0);
      op(3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000);
      tick();
      chk("subb_ovf", 32'(flags()), 32'hC);
      chk("subb_cnt", 32'(bus.ovf_cnt), 32'h1);

      // saturation at 3 over further overflowing ADDs
      for (int i = 0; i < 4; i++) begin
         op(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000);
         tick();
         chk($sformatf("sat_cnt%0d", i), 32'(bus.ovf_cnt), (i == 0) ? 32'h2 : 32'h3);
      end
      chk("sat_so", 32'(bus.so_flag), 32'h1);

      // clear coincident with overflow: set/increment wins
      op(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000);
      bus.sticky_clr = 1'b1;
      tick();
      chk("clr_ovf_so", 32'(bus.so_flag), 32'h1);
      chk("clr_ovf_cnt", 32'(bus.ovf_cnt), 32'h1);

      // reset beats flag_ld
      rst            = 1'b1;
      bus.flag_ld    = 1'b1;
      bus.flag_wdata = 4'hF;
      tick();
      rst = 1'b0;
      chk("rst_ld_flags", 32'(flags()), 32'h0);
      chk("rst_ld_cnt", 32'(bus.ovf_cnt), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
